// File: rtl/clock_set_ctrl.sv
// Time-set controller for a BCD hh:mm:ss timer: RUN -> edit hour/minute/second -> one-cycle load strobe.
// Optional alarm strobe when CLOCK_SET_ALARM_EN is defined.
module clock_set_ctrl #(
  parameter int TIMEOUT = 1000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       MODE,
  input  logic       INC,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
`ifdef CLOCK_SET_ALARM_EN
  input  logic [7:0] AL_H,
  input  logic [7:0] AL_M,
  output logic       ALARM,
`endif
  output logic       CE_OUT,
  output logic       PE_OUT,
  output logic [7:0] D_H,
  output logic [7:0] D_M,
  output logic [7:0] D_S,
  output logic [1:0] SEL
);

  // state | meaning
  // RUN   | timer counting, keys other than MODE ignored
  // SET_H | editing hour field
  // SET_M | editing minute field
  // SET_S | editing second field
  // LOAD  | one-cycle load strobe, then back to RUN
  typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, LOAD} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic            mode_prev, inc_prev;
  logic            mode_ev, inc_ev;
  logic            in_set, timeout;
  logic [CW-1:0]   idle_cnt;
  logic [7:0]      edit_h, edit_m, edit_s;

  // Out-of-range or non-BCD values wrap to 00 rather than propagating garbage.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v >= max || v[3:0] > 4'd9 || v[7:4] > 4'd9) return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign mode_ev = MODE & ~mode_prev;
  assign inc_ev  = INC & ~inc_prev;
  assign in_set  = (state == SET_H) || (state == SET_M) || (state == SET_S);
  assign timeout = in_set && !mode_ev && !inc_ev && (idle_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CP) begin
    if (CR) begin
      state     <= RUN;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
    end else begin
      state     <= state_nxt;
      mode_prev <= MODE;
      inc_prev  <= INC;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:   if (mode_ev) state_nxt = SET_H;
      SET_H: if (mode_ev) state_nxt = SET_M; else if (timeout) state_nxt = RUN;
      SET_M: if (mode_ev) state_nxt = SET_S; else if (timeout) state_nxt = RUN;
      SET_S: if (mode_ev) state_nxt = LOAD;  else if (timeout) state_nxt = RUN;
      LOAD:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    CE_OUT = 1'b0;
    PE_OUT = 1'b0;
    SEL    = 2'b00;
    case (state)
      RUN:   CE_OUT = 1'b1;
      SET_H: SEL = 2'b01;
      SET_M: SEL = 2'b10;
      SET_S: SEL = 2'b11;
      LOAD:  PE_OUT = 1'b1;
      default: CE_OUT = 1'b1;
    endcase
  end

  always_ff @(posedge CP) begin
    if (CR) idle_cnt <= '0;
    else if (in_set && !mode_ev && !inc_ev && !timeout) idle_cnt <= idle_cnt + 1'b1;
    else idle_cnt <= '0;
  end

  // MODE takes precedence: a simultaneous INC is dropped.
  always_ff @(posedge CP) begin
    if (CR) begin
      edit_h <= 8'h00;
      edit_m <= 8'h00;
      edit_s <= 8'h00;
    end else begin
      case (state)
        RUN: if (mode_ev) begin
          edit_h <= Q_H;
          edit_m <= Q_M;
          edit_s <= Q_S;
        end
        SET_H: if (inc_ev && !mode_ev) edit_h <= bcd_inc(edit_h, 8'h23);
        SET_M: if (inc_ev && !mode_ev) edit_m <= bcd_inc(edit_m, 8'h59);
        SET_S: if (inc_ev && !mode_ev) edit_s <= bcd_inc(edit_s, 8'h59);
        default: ;
      endcase
    end
  end

  assign D_H = edit_h;
  assign D_M = edit_m;
  assign D_S = edit_s;

`ifdef CLOCK_SET_ALARM_EN
  logic match, match_q;

  assign match = (state == RUN) && ({Q_H, Q_M, Q_S} == {AL_H, AL_M, 8'h00});

  always_ff @(posedge CP) begin
    if (CR) begin
      match_q <= 1'b0;
      ALARM   <= 1'b0;
    end else begin
      match_q <= match;
      ALARM   <= match & ~match_q;
    end
  end
`endif

endmodule
